// File: rtl/led_scan_driver_pkg.sv
// rtl/led_scan_driver_pkg.sv - shared constants for the eight-digit LED scan driver
package led_scan_driver_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] DIG_IDLE = 8'hFF;

  // Segment codes, bit6..0 = g..a, 1 = segment on
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/led_scan_driver_if.sv
// rtl/led_scan_driver_if.sv - data/load inputs and pin outputs of the LED scan driver
interface led_scan_driver_if;

  logic [31:0] bcdIn;
  logic [7:0]  dpIn;
  logic        load;
  logic        pendOut;
  logic [7:0]  segOut;
  logic [7:0]  digOut;
  logic        frameDone;

  modport master (
    output bcdIn, dpIn, load,
    input  pendOut, segOut, digOut, frameDone
  );

  modport slave (
    input  bcdIn, dpIn, load,
    output pendOut, segOut, digOut, frameDone
  );

endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD nibble to seven-segment pattern, non-decimal nibbles blank
module seg7_decode
  import led_scan_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/led_scan_driver.sv
// rtl/led_scan_driver.sv - 8-digit multiplexed seven-segment scanner; LED_SCAN_LZB_EN enables leading-zero blanking
module led_scan_driver
  import led_scan_driver_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
)
(
  input  logic             clk,
  input  logic             rst,
  led_scan_driver_if.slave bus
);

  localparam int             CW       = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_SHOW = CW'(BLANK_CYCLES);
  localparam logic [2:0]     IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [31:0]   pend_bcd, disp_bcd;
  logic [7:0]    pend_dp, disp_dp;
  logic          pend_flag;
  logic [7:0]    seg_q, dig_q;
  logic          frame_q;

  logic          last_cnt, boundary, show_n, lz_blank;
  logic [3:0]    digit_n;
  logic [6:0]    dec_seg;
  logic [7:0]    seg_n, dig_n;

  seg7_decode u_dec (
    .bcd (digit_n),
    .seg (dec_seg)
  );

  // Outputs are built from the next counter state so they line up with cnt/idx
  // in the cycle they are visible; display only changes into a BLANK cycle.
  always_comb begin
    last_cnt = (cnt == CNT_LAST);
    boundary = last_cnt && (idx == IDX_LAST);
    cnt_n    = last_cnt ? '0 : cnt + CW'(1);
    idx_n    = last_cnt ? idx + 3'd1 : idx;
    show_n   = (cnt_n >= CNT_SHOW);
    digit_n  = disp_bcd[{idx_n, 2'b00} +: 4];
`ifdef LED_SCAN_LZB_EN
    lz_blank = (idx_n != 3'd0) && ((disp_bcd >> {idx_n, 2'b00}) == 32'd0);
`else
    lz_blank = 1'b0;
`endif
    seg_n    = show_n ? {disp_dp[idx_n], (lz_blank ? SEG_BLANK : dec_seg)} : 8'h00;
    dig_n    = show_n ? ~(8'h01 << idx_n) : DIG_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= 3'd0;
      pend_bcd  <= 32'd0;
      pend_dp   <= 8'd0;
      disp_bcd  <= 32'd0;
      disp_dp   <= 8'd0;
      pend_flag <= 1'b0;
      seg_q     <= 8'h00;
      dig_q     <= DIG_IDLE;
      frame_q   <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      idx     <= idx_n;
      seg_q   <= seg_n;
      dig_q   <= dig_n;
      frame_q <= (cnt_n == CNT_LAST) && (idx_n == IDX_LAST);
      if (bus.load && boundary) begin
        disp_bcd  <= bus.bcdIn;
        disp_dp   <= bus.dpIn;
        pend_flag <= 1'b0;
      end else if (bus.load) begin
        pend_bcd  <= bus.bcdIn;
        pend_dp   <= bus.dpIn;
        pend_flag <= 1'b1;
      end else if (boundary && pend_flag) begin
        disp_bcd  <= pend_bcd;
        disp_dp   <= pend_dp;
        pend_flag <= 1'b0;
      end
    end
  end

  assign bus.pendOut   = pend_flag;
  assign bus.segOut    = seg_q;
  assign bus.digOut    = dig_q;
  assign bus.frameDone = frame_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// tb/tb_led_scan_driver.sv - randomized model-checked bench for led_scan_driver
module tb_led_scan_driver;

  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 8 * DC;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_scan_driver_if bus ();

  led_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model state: t counts cycles since reset release; position in frame/slot is pure arithmetic on t
  int          t        = 0;
  int          last_pos = -1;
  logic [31:0] m_disp   = 32'd0;
  logic [7:0]  m_dp     = 8'd0;
  logic [31:0] m_pbcd   = 32'd0;
  logic [7:0]  m_pdp    = 8'd0;
  logic        m_pend   = 1'b0;

`ifdef LED_SCAN_LZB_EN
  localparam logic [7:0] ZLEAD = 8'h00;
`else
  localparam logic [7:0] ZLEAD = 8'h3F;
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0d)", name, got, exp, t);
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h67;
      default: return 7'h00;
    endcase
  endfunction

  always @(negedge clk) begin : model
    int c, ix, pos;
    logic [7:0] es, ed;
    logic bnd;
    if (rst) begin
      chk("rst_digOut", {24'd0, bus.digOut}, 32'hFF);
      chk("rst_segOut", {24'd0, bus.segOut}, 32'h00);
      chk("rst_frameDone", {31'd0, bus.frameDone}, 32'd0);
      chk("rst_pendOut", {31'd0, bus.pendOut}, 32'd0);
      t = 0; last_pos = -1;
      m_disp = 32'd0; m_dp = 8'd0; m_pend = 1'b0;
    end else begin
      c   = t % DC;
      ix  = (t / DC) % 8;
      pos = t % FRAME;
      bnd = (pos == FRAME - 1);
      if (c < BC) begin
        ed = 8'hFF;
        es = 8'h00;
      end else begin
        ed = ~(8'h01 << ix);
        es = {m_dp[ix], seg7(4'((m_disp >> (4 * ix)) & 32'hF))};
`ifdef LED_SCAN_LZB_EN
        if (ix > 0 && (m_disp >> (4 * ix)) == 32'd0) es[6:0] = 7'h00;
`endif
      end
      chk("digOut", {24'd0, bus.digOut}, {24'd0, ed});
      chk("segOut", {24'd0, bus.segOut}, {24'd0, es});
      chk("frameDone", {31'd0, bus.frameDone}, {31'd0, bnd});
      chk("pendOut", {31'd0, bus.pendOut}, {31'd0, m_pend});
      if (bus.load && bnd) begin
        m_disp = bus.bcdIn; m_dp = bus.dpIn; m_pend = 1'b0;
      end else if (bus.load) begin
        m_pbcd = bus.bcdIn; m_pdp = bus.dpIn; m_pend = 1'b1;
      end else if (bnd && m_pend) begin
        m_disp = m_pbcd; m_dp = m_pdp; m_pend = 1'b0;
      end
      last_pos = pos;
      t++;
    end
  end

  task automatic wait_pos(input int d, input int c);
    int  target;
    bit  hit;
    target = d * DC + c;
    hit    = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk); #1;
      if (last_pos == target) hit = 1'b1;
    end
    if (!hit) begin
      n_total++;
      $display("FAIL wait_pos: frame position %0d not reached, got none, expected within 300 cycles", target);
    end
  endtask

  task automatic chk_pin(input string name, input logic [7:0] edig, input logic [7:0] eseg);
    chk({name, "_dig"}, {24'd0, bus.digOut}, {24'd0, edig});
    chk({name, "_seg"}, {24'd0, bus.segOut}, {24'd0, eseg});
  endtask

  task automatic do_load(input logic [31:0] b, input logic [7:0] d);
    @(posedge clk); #1;
    bus.bcdIn = b; bus.dpIn = d; bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.bcdIn = $urandom; bus.dpIn = 8'($urandom);
  endtask

  initial begin
    bus.load  = 1'b0;
    bus.bcdIn = $urandom;
    bus.dpIn  = 8'($urandom);
    rst       = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    chk_pin("reset", 8'hFF, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    wait_pos(0, 1); chk_pin("first_blank", 8'hFF, 8'h00);
    wait_pos(0, 2); chk_pin("first_show", 8'hFE, 8'h3F);

    do_load(32'h76543210, 8'h00);
    @(negedge clk); #1;
    chk("pend_after_load", {31'd0, bus.pendOut}, 32'd1);
    wait_pos(7, 7);
    chk("boundary_frameDone", {31'd0, bus.frameDone}, 32'd1);
    wait_pos(0, 1);
    chk("pend_cleared", {31'd0, bus.pendOut}, 32'd0);
    wait_pos(0, 2); chk_pin("d0_76543210", 8'hFE, 8'h3F);
    wait_pos(3, 2); chk_pin("d3_76543210", 8'hF7, 8'h4F);
    wait_pos(7, 7); chk_pin("d7_76543210", 8'h7F, 8'h07);

    do_load(32'h11111111, 8'h00);
    repeat (3) @(posedge clk);
    do_load(32'h22222222, 8'h00);
    wait_pos(7, 7);
    wait_pos(0, 3); chk_pin("last_load_wins", 8'hFE, 8'h5B);
    wait_pos(2, 5); chk_pin("last_load_wins_d2", 8'hFB, 8'h5B);

    @(posedge clk); #1;
    bus.bcdIn = 32'h33333333; bus.dpIn = 8'h00; bus.load = 1'b1;
    @(posedge clk); #1;
    bus.bcdIn = 32'h88888888;
    @(posedge clk); #1;
    bus.load = 1'b0;
    wait_pos(7, 7);
    wait_pos(4, 2); chk_pin("back_to_back", 8'hEF, 8'h7F);

    do_load(32'h55555555, 8'h00);
    wait_pos(7, 6);
    @(posedge clk); #1;
    bus.bcdIn = 32'h99999999; bus.dpIn = 8'h00; bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
    @(negedge clk); #1;
    chk("pend_boundary_load", {31'd0, bus.pendOut}, 32'd0);
    wait_pos(1, 2); chk_pin("boundary_load", 8'hFD, 8'h67);

    do_load(32'h0000000A, 8'h01);
    wait_pos(7, 7);
    wait_pos(0, 2); chk_pin("hex_a_dp", 8'hFE, 8'h80);
    wait_pos(1, 2); chk_pin("zero_d1", 8'hFD, ZLEAD);

    do_load(32'h00000105, 8'h00);
    wait_pos(7, 7);
    wait_pos(0, 2); chk_pin("v105_d0", 8'hFE, 8'h6D);
    wait_pos(1, 2); chk_pin("v105_d1", 8'hFD, 8'h3F);
    wait_pos(2, 2); chk_pin("v105_d2", 8'hFB, 8'h06);
    wait_pos(3, 2); chk_pin("v105_d3", 8'hF7, ZLEAD);
    wait_pos(7, 2); chk_pin("v105_d7", 8'h7F, ZLEAD);

    do_load(32'h00000000, 8'h00);
    wait_pos(7, 7);
    wait_pos(0, 2); chk_pin("zero_d0", 8'hFE, 8'h3F);
    wait_pos(1, 2); chk_pin("zero_d1b", 8'hFD, ZLEAD);

    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      bus.load  = ($urandom % 16) == 0;
      bus.bcdIn = $urandom;
      bus.dpIn  = 8'($urandom);
    end
    @(posedge clk); #1;
    bus.load = 1'b0;

    wait_pos(5, 3);
    do_load($urandom, 8'($urandom));
    #2 rst = 1'b1;
    #1;
    chk_pin("async_rst", 8'hFF, 8'h00);
    chk("async_rst_pend", {31'd0, bus.pendOut}, 32'd0);
    chk("async_rst_fd", {31'd0, bus.frameDone}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_pos(0, 2); chk_pin("restart_d0", 8'hFE, 8'h3F);
    chk("restart_pend", {31'd0, bus.pendOut}, 32'd0);
    wait_pos(5, 2); chk_pin("restart_d5", 8'hDF, ZLEAD);
    wait_pos(7, 7);
    wait_pos(0, 2); chk_pin("discarded_pending", 8'hFE, 8'h3F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
